// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin arbiter sharing one UART byte transmitter
// Optional watchdog: define UART_TX_SCHED_TIMEOUT_EN to add the TO_W counter and timeout_err.
module uart_tx_scheduler #(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   parameter int IDW  = 2
`ifdef UART_TX_SCHED_TIMEOUT_EN
   ,
   parameter int              TO_W     = 16,
   parameter logic [TO_W-1:0] TO_LIMIT = 16'hFFFF
`endif
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ack,
   output logic [NREQ-1:0]    req_done,
   output logic               tx_en,
   output logic [DW-1:0]      tx_byte,
   input  logic               tx_busy,
   input  logic               tx_done,
   output logic [IDW-1:0]     grant_id,
`ifdef UART_TX_SCHED_TIMEOUT_EN
   output logic               timeout_err,
`endif
   output logic               sched_busy
);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, RELEASE} state_t;

   state_t            state, state_nxt;
   logic [IDW-1:0]    rr_ptr, rr_ptr_nxt;
   logic [IDW-1:0]    grant_nxt;
   logic [DW-1:0]     tx_byte_nxt;
   logic              tx_en_nxt;
   logic              sched_busy_nxt;
   logic [NREQ-1:0]   req_ack_nxt;
   logic [NREQ-1:0]   req_done_nxt;
   logic              win_found;
   logic [IDW-1:0]    win_id;
   logic [IDW-1:0]    cand;
`ifdef UART_TX_SCHED_TIMEOUT_EN
   logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
   logic              timeout_err_nxt;
`endif

   // Walk downward so the candidate closest after rr_ptr is the last one written.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int i = NREQ; i >= 1; i--) begin
         cand = IDW'((int'(rr_ptr) + i) % NREQ);
         if (req[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      rr_ptr_nxt     = rr_ptr;
      grant_nxt      = grant_id;
      tx_byte_nxt    = tx_byte;
      tx_en_nxt      = tx_en;
      sched_busy_nxt = sched_busy;
      req_ack_nxt    = '0;
      req_done_nxt   = '0;

      case (state)
         IDLE: begin
            if (win_found) begin
               grant_nxt      = win_id;
               tx_byte_nxt    = req_data[int'(win_id)*DW +: DW];
               tx_en_nxt      = 1'b1;
               sched_busy_nxt = 1'b1;
               state_nxt      = LAUNCH;
            end
         end
         LAUNCH: begin
            // A stale tx_done is ignored here; only busy proves our byte was taken.
            if (tx_busy) begin
               tx_en_nxt             = 1'b0;
               req_ack_nxt[grant_id] = 1'b1;
               state_nxt             = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (tx_done) state_nxt = RELEASE;
         end
         RELEASE: begin
            if (!tx_done) begin
               req_done_nxt[grant_id] = 1'b1;
               rr_ptr_nxt             = grant_id;
               sched_busy_nxt         = 1'b0;
               state_nxt              = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

`ifdef UART_TX_SCHED_TIMEOUT_EN
      to_cnt_nxt      = '0;
      timeout_err_nxt = 1'b0;
      if (state != IDLE) begin
         if (to_cnt == TO_LIMIT - 1'b1) begin
            state_nxt       = IDLE;
            tx_en_nxt       = 1'b0;
            sched_busy_nxt  = 1'b0;
            req_ack_nxt     = '0;
            req_done_nxt    = '0;
            rr_ptr_nxt      = grant_id;
            timeout_err_nxt = 1'b1;
         end else if (state_nxt == state) begin
            to_cnt_nxt = to_cnt + 1'b1;
         end
      end
`endif

      if (rst) begin
         state_nxt      = IDLE;
         rr_ptr_nxt     = IDW'(NREQ - 1);
         grant_nxt      = '0;
         tx_byte_nxt    = '0;
         tx_en_nxt      = 1'b0;
         sched_busy_nxt = 1'b0;
         req_ack_nxt    = '0;
         req_done_nxt   = '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
         to_cnt_nxt      = '0;
         timeout_err_nxt = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state      <= IDLE;
         rr_ptr     <= IDW'(NREQ - 1);
         grant_id   <= '0;
         tx_byte    <= '0;
         tx_en      <= 1'b0;
         sched_busy <= 1'b0;
         req_ack    <= '0;
         req_done   <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
         to_cnt      <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         rr_ptr     <= rr_ptr_nxt;
         grant_id   <= grant_nxt;
         tx_byte    <= tx_byte_nxt;
         tx_en      <= tx_en_nxt;
         sched_busy <= sched_busy_nxt;
         req_ack    <= req_ack_nxt;
         req_done   <= req_done_nxt;
`ifdef UART_TX_SCHED_TIMEOUT_EN
         to_cnt      <= to_cnt_nxt;
         timeout_err <= timeout_err_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler
// Timeout steps are included when UART_TX_SCHED_TIMEOUT_EN is defined.
module tb_uart_tx_scheduler;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_ack;
   logic [3:0]  req_done;
   logic        tx_en;
   logic [7:0]  tx_byte;
   logic        tx_busy;
   logic        tx_done;
   logic [1:0]  grant_id;
   logic        sched_busy;
`ifdef UART_TX_SCHED_TIMEOUT_EN
   logic        timeout_err;
   int          wait_cycles;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] byte_of [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};

   always #5 clk = ~clk;

`ifdef UART_TX_SCHED_TIMEOUT_EN
   uart_tx_scheduler #(.NREQ(4), .DW(8), .IDW(2), .TO_W(16), .TO_LIMIT(16'd20)) dut (
`else
   uart_tx_scheduler #(.NREQ(4), .DW(8), .IDW(2)) dut (
`endif
      .clk        (clk),
      .arst_n     (arst_n),
      .rst        (rst),
      .req        (req),
      .req_data   (req_data),
      .req_ack    (req_ack),
      .req_done   (req_done),
      .tx_en      (tx_en),
      .tx_byte    (tx_byte),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .grant_id   (grant_id),
`ifdef UART_TX_SCHED_TIMEOUT_EN
      .timeout_err(timeout_err),
`endif
      .sched_busy (sched_busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // From LAUNCH: transmitter accepts, finishes, returns to idle.
   task automatic complete(input int id);
      tx_busy = 1'b1;
      step();
      check("ack", 32'(req_ack), 32'(4'b0001 << id));
      check("ack_tx_en", 32'(tx_en), 32'd0);
      tx_busy = 1'b0;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();
      check("done", 32'(req_done), 32'(4'b0001 << id));
      check("done_busy", 32'(sched_busy), 32'd0);
   endtask

   task automatic serve(input int id);
      step();
      check("grant", 32'(grant_id), 32'(id));
      check("grant_tx_en", 32'(tx_en), 32'd1);
      check("grant_byte", 32'(tx_byte), 32'(byte_of[id]));
      complete(id);
   endtask

   initial begin
      arst_n   = 1'b0;
      rst      = 1'b0;
      req      = 4'b0000;
      req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
      tx_busy  = 1'b0;
      tx_done  = 1'b0;
      step();
      step();
      check("rst_tx_en", 32'(tx_en), 32'd0);
      check("rst_busy", 32'(sched_busy), 32'd0);
      check("rst_ack", 32'(req_ack), 32'd0);
      check("rst_done", 32'(req_done), 32'd0);
      check("rst_grant", 32'(grant_id), 32'd0);
      check("rst_byte", 32'(tx_byte), 32'd0);
      arst_n = 1'b1;
      step();
      check("idle_no_req", 32'(sched_busy), 32'd0);

      // Single request with a three-cycle done level.
      req = 4'b0100;
      step();
      check("s_tx_en", 32'(tx_en), 32'd1);
      check("s_byte", 32'(tx_byte), 32'hA5);
      check("s_grant", 32'(grant_id), 32'd2);
      check("s_busy", 32'(sched_busy), 32'd1);
      tx_busy = 1'b1;
      step();
      check("s_ack", 32'(req_ack), 32'h4);
      check("s_ack_tx_en", 32'(tx_en), 32'd0);
      req     = 4'b0000;
      tx_busy = 1'b0;
      tx_done = 1'b1;
      step();
      check("s_ack_pulse", 32'(req_ack), 32'd0);
      step();
      step();
      check("s_done_early", 32'(req_done), 32'd0);
      tx_done = 1'b0;
      step();
      check("s_done", 32'(req_done), 32'h4);
      check("s_done_busy", 32'(sched_busy), 32'd0);
      step();
      check("s_done_pulse", 32'(req_done), 32'd0);

      // Synchronous clear restores rr_ptr, then round-robin with all requesting.
      rst = 1'b1;
      step();
      rst = 1'b0;
      req = 4'b1111;
      serve(0);
      serve(1);
      serve(2);
      serve(3);
      serve(0);
      req = 4'b0000;
      step();

      // Late arrival on requester 3 during owner 0's frame.
      req = 4'b0001;
      step();
      check("late_grant0", 32'(grant_id), 32'd0);
      tx_busy = 1'b1;
      step();
      check("late_ack0", 32'(req_ack), 32'h1);
      tx_busy = 1'b0;
      req     = 4'b1000;
      step();
      check("late_hold", 32'(grant_id), 32'd0);
      tx_done = 1'b1;
      step();
      check("late_hold2", 32'(grant_id), 32'd0);
      tx_done = 1'b0;
      step();
      check("late_done0", 32'(req_done), 32'h1);
      step();
      check("late_grant3", 32'(grant_id), 32'd3);
      check("late_tx_en", 32'(tx_en), 32'd1);
      complete(3);
      req = 4'b0000;

      // Reset mid-frame while owner 1 waits for done.
      req = 4'b0010;
      step();
      check("mr_grant", 32'(grant_id), 32'd1);
      tx_busy = 1'b1;
      step();
      check("mr_ack", 32'(req_ack), 32'h2);
      tx_busy = 1'b0;
      req     = 4'b0000;
      rst     = 1'b1;
      step();
      check("mr_tx_en", 32'(tx_en), 32'd0);
      check("mr_busy", 32'(sched_busy), 32'd0);
      check("mr_grant0", 32'(grant_id), 32'd0);
      check("mr_byte", 32'(tx_byte), 32'd0);
      check("mr_done", 32'(req_done), 32'd0);
      rst     = 1'b0;
      tx_done = 1'b1;
      step();
      check("mr_no_done", 32'(req_done), 32'd0);
      tx_done = 1'b0;
      req     = 4'b0011;
      serve(0);
      req = 4'b0000;
      step();

      // Stale done on LAUNCH entry; busy and done together on acceptance.
      req     = 4'b0100;
      tx_done = 1'b1;
      step();
      check("st_grant", 32'(grant_id), 32'd2);
      step();
      step();
      check("st_no_ack", 32'(req_ack), 32'd0);
      check("st_tx_en", 32'(tx_en), 32'd1);
      tx_busy = 1'b1;
      step();
      check("st_ack", 32'(req_ack), 32'h4);
      tx_busy = 1'b0;
      req     = 4'b0000;
      step();
      check("st_no_done", 32'(req_done), 32'd0);
      check("st_busy", 32'(sched_busy), 32'd1);
      tx_done = 1'b0;
      step();
      check("st_done", 32'(req_done), 32'h4);

`ifdef UART_TX_SCHED_TIMEOUT_EN
      // Watchdog: transmitter never accepts requester 1's byte.
      req = 4'b0010;
      step();
      check("to_grant", 32'(grant_id), 32'd1);
      check("to_err_idle", 32'(timeout_err), 32'd0);
      wait_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         wait_cycles++;
         if (req_ack != 4'b0000) check("to_no_ack", 32'(req_ack), 32'd0);
         if (timeout_err) break;
      end
      check("to_err", 32'(timeout_err), 32'd1);
      check("to_cycles", 32'(wait_cycles), 32'd20);
      check("to_busy", 32'(sched_busy), 32'd0);
      check("to_tx_en", 32'(tx_en), 32'd0);
      check("to_no_done", 32'(req_done), 32'd0);
      req = 4'b0011;
      serve(0);
      check("to_err_pulse", 32'(timeout_err), 32'd0);
      req = 4'b0000;
`endif

      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
